// File: rtl/hyper_frdram_sched.sv
// hyper_frdram_sched: four-channel round-robin burst scheduler for the DRAM-to-LSAB mover.
// Optional WAIT_START watchdog is enabled by defining FRDRAM_SCHED_TIMEOUT_EN.
module hyper_frdram_sched #(
   parameter int MAX_BURST   = 16,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LOAD,
   input  logic [1:0]  LOAD_CH,
   input  logic [11:0] LOAD_ADDR,
   input  logic [7:0]  LOAD_LEN,
   output logic        LOAD_ACK,
   input  logic [3:0]  LSAB_FULL,
   output logic [3:0]  CH_BUSY,
   output logic [3:0]  CH_DONE,
   output logic [3:0]  CH_ERR,
   output logic [11:0] MV_START_ADDRESS,
   output logic [4:0]  MV_COUNT_REQ,
   output logic [1:0]  MV_SECTION,
   output logic        MV_ISSUE,
   input  logic [4:0]  MV_COUNT_SENT,
   input  logic        MV_WORKING
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_START,
      S_WAIT_END,
      S_ACCOUNT
   } state_t;

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);

   state_t            state_q, state_d;
   logic [3:0][11:0]  addr_q, addr_d;
   logic [3:0][7:0]   rem_q, rem_d;
   logic [3:0]        busy_q, busy_d;
   logic [1:0]        rr_q, rr_d;
   logic [1:0]        ch_q, ch_d;
   logic [4:0]        burst_q, burst_d;
   logic              load_ack_q, load_ack_d;
   logic [3:0]        done_q, done_d;
   logic [3:0]        err_q, err_d;
   logic              mv_issue_q, mv_issue_d;
   logic [11:0]       mv_addr_q, mv_addr_d;
   logic [4:0]        mv_cnt_q, mv_cnt_d;
   logic [1:0]        mv_sec_q, mv_sec_d;

   logic [3:0]        ready;
   logic              found;
   logic [1:0]        pick;
   logic [1:0]        idx;
   logic [4:0]        gburst;
   logic [4:0]        n_sent;
   logic [7:0]        rem_left;

`ifdef FRDRAM_SCHED_TIMEOUT_EN
   localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYC - 1);
   logic [15:0] wd_q, wd_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYC);
`endif

   // First ready channel at or after the round-robin pointer.
   always_comb begin
      ready = busy_q & ~LSAB_FULL;
      found = 1'b0;
      pick  = rr_q;
      idx   = rr_q;
      for (int i = 0; i < 4; i++) begin
         idx = rr_q + 2'(i);
         if (!found && ready[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      gburst = (rem_q[pick] < MAX_B) ? rem_q[pick][4:0] : MAX_B[4:0];
      n_sent = (MV_COUNT_SENT < burst_q) ? MV_COUNT_SENT : burst_q;
      rem_left = rem_q[ch_q] - {3'b000, n_sent};
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      busy_d     = busy_q;
      rr_d       = rr_q;
      ch_d       = ch_q;
      burst_d    = burst_q;
      load_ack_d = 1'b0;
      done_d     = 4'd0;
      err_d      = 4'd0;
      mv_issue_d = 1'b0;
      mv_addr_d  = mv_addr_q;
      mv_cnt_d   = mv_cnt_q;
      mv_sec_d   = mv_sec_q;
`ifdef FRDRAM_SCHED_TIMEOUT_EN
      wd_d       = wd_q;
`endif

      // A retiring channel is still busy here, so a LOAD to it is refused.
      if (LOAD && !busy_q[LOAD_CH] && LOAD_LEN != 8'd0) begin
         addr_d[LOAD_CH] = LOAD_ADDR;
         rem_d[LOAD_CH]  = LOAD_LEN;
         busy_d[LOAD_CH] = 1'b1;
         load_ack_d      = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               ch_d       = pick;
               burst_d    = gburst;
               mv_addr_d  = addr_q[pick];
               mv_cnt_d   = gburst - 5'd1;
               mv_sec_d   = pick;
               mv_issue_d = 1'b1;
               state_d    = S_ISSUE;
`ifdef FRDRAM_SCHED_TIMEOUT_EN
               wd_d       = 16'd0;
`endif
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_START;
`ifdef FRDRAM_SCHED_TIMEOUT_EN
            wd_d    = wd_q + 16'd1;
`endif
         end
         S_WAIT_START: begin
            if (MV_WORKING) begin
               state_d = S_WAIT_END;
`ifdef FRDRAM_SCHED_TIMEOUT_EN
            end else if (wd_q >= WD_LIM) begin
               busy_d[ch_q] = 1'b0;
               err_d[ch_q]  = 1'b1;
               rr_d         = ch_q + 2'd1;
               state_d      = S_IDLE;
            end else begin
               wd_d = wd_q + 16'd1;
`endif
            end
         end
         S_WAIT_END: begin
            if (!MV_WORKING) begin
               state_d = S_ACCOUNT;
            end
         end
         S_ACCOUNT: begin
            addr_d[ch_q] = addr_q[ch_q] + 12'(n_sent);
            rem_d[ch_q]  = rem_left;
            if (rem_left == 8'd0) begin
               busy_d[ch_q] = 1'b0;
               done_d[ch_q] = 1'b1;
            end
            rr_d    = ch_q + 2'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         busy_q     <= 4'd0;
         rr_q       <= 2'd0;
         ch_q       <= 2'd0;
         burst_q    <= 5'd0;
         load_ack_q <= 1'b0;
         done_q     <= 4'd0;
         err_q      <= 4'd0;
         mv_issue_q <= 1'b0;
         mv_addr_q  <= 12'd0;
         mv_cnt_q   <= 5'd0;
         mv_sec_q   <= 2'd0;
`ifdef FRDRAM_SCHED_TIMEOUT_EN
         wd_q       <= 16'd0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         busy_q     <= busy_d;
         rr_q       <= rr_d;
         ch_q       <= ch_d;
         burst_q    <= burst_d;
         load_ack_q <= load_ack_d;
         done_q     <= done_d;
         err_q      <= err_d;
         mv_issue_q <= mv_issue_d;
         mv_addr_q  <= mv_addr_d;
         mv_cnt_q   <= mv_cnt_d;
         mv_sec_q   <= mv_sec_d;
`ifdef FRDRAM_SCHED_TIMEOUT_EN
         wd_q       <= wd_d;
`endif
      end
   end

   assign LOAD_ACK         = load_ack_q;
   assign CH_BUSY          = busy_q;
   assign CH_DONE          = done_q;
   assign CH_ERR           = err_q;
   assign MV_ISSUE         = mv_issue_q;
   assign MV_START_ADDRESS = mv_addr_q;
   assign MV_COUNT_REQ     = mv_cnt_q;
   assign MV_SECTION       = mv_sec_q;

endmodule

// File: tb/tb_hyper_frdram_sched.sv
// tb_hyper_frdram_sched: directed vectors and corner sequences for hyper_frdram_sched.
// Includes a behavioural mover that echoes bursts with a configurable word cap.
module tb_hyper_frdram_sched;

   logic        CLK;
   logic        RST;
   logic        LOAD;
   logic [1:0]  LOAD_CH;
   logic [11:0] LOAD_ADDR;
   logic [7:0]  LOAD_LEN;
   logic        LOAD_ACK;
   logic [3:0]  LSAB_FULL;
   logic [3:0]  CH_BUSY;
   logic [3:0]  CH_DONE;
   logic [3:0]  CH_ERR;
   logic [11:0] MV_START_ADDRESS;
   logic [4:0]  MV_COUNT_REQ;
   logic [1:0]  MV_SECTION;
   logic        MV_ISSUE;
   logic [4:0]  MV_COUNT_SENT;
   logic        MV_WORKING;

   hyper_frdram_sched #(.MAX_BURST(16), .TIMEOUT_CYC(15)) dut (
      .CLK(CLK), .RST(RST),
      .LOAD(LOAD), .LOAD_CH(LOAD_CH), .LOAD_ADDR(LOAD_ADDR),
      .LOAD_LEN(LOAD_LEN), .LOAD_ACK(LOAD_ACK),
      .LSAB_FULL(LSAB_FULL), .CH_BUSY(CH_BUSY),
      .CH_DONE(CH_DONE), .CH_ERR(CH_ERR),
      .MV_START_ADDRESS(MV_START_ADDRESS), .MV_COUNT_REQ(MV_COUNT_REQ),
      .MV_SECTION(MV_SECTION), .MV_ISSUE(MV_ISSUE),
      .MV_COUNT_SENT(MV_COUNT_SENT), .MV_WORKING(MV_WORKING)
   );

   int tests = 0;
   int fails = 0;
   int sent_cap = 31;
   bit stall = 0;
   int mv_left = 0;
   int done_cnt [4];
   int err_cnt [4];
   logic [11:0] iss_addr [$];
   logic [4:0]  iss_req [$];
   logic [1:0]  iss_sec [$];

   typedef struct {
      logic [1:0]  ch;
      logic [11:0] addr;
      logic [7:0]  len;
      int          cap;
      int          nb;
      logic [11:0] ea [4];
      logic [4:0]  er [4];
   } vec_t;
   vec_t vt [6];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Mover model: raise WORKING one half-cycle after the issue, hold it for burst+1 negedges.
   initial begin
      int req1;
      MV_WORKING = 1'b0;
      MV_COUNT_SENT = 5'd0;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            mv_left = 0;
            MV_WORKING = 1'b0;
         end else if (mv_left > 0) begin
            mv_left--;
            if (mv_left == 0) MV_WORKING = 1'b0;
         end else if (MV_ISSUE) begin
            iss_addr.push_back(MV_START_ADDRESS);
            iss_req.push_back(MV_COUNT_REQ);
            iss_sec.push_back(MV_SECTION);
            if (!stall) begin
               req1 = int'(MV_COUNT_REQ) + 1;
               MV_COUNT_SENT = 5'((req1 < sent_cap) ? req1 : sent_cap);
               MV_WORKING = 1'b1;
               mv_left = req1 + 1;
            end
         end
      end
   end

   initial begin
      for (int c = 0; c < 4; c++) begin
         done_cnt[c] = 0;
         err_cnt[c] = 0;
      end
      forever begin
         @(negedge CLK);
         for (int c = 0; c < 4; c++) begin
            if (CH_DONE[c]) done_cnt[c]++;
            if (CH_ERR[c]) err_cnt[c]++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [1:0] ch, input logic [11:0] a,
                          input logic [7:0] len, input logic exp_ack);
      @(negedge CLK);
      LOAD = 1'b1;
      LOAD_CH = ch;
      LOAD_ADDR = a;
      LOAD_LEN = len;
      @(negedge CLK);
      LOAD = 1'b0;
      check("load_ack", 32'(LOAD_ACK), 32'(exp_ack));
   endtask

   task automatic wait_done(input int ch, input int prev);
      int k = 0;
      while (done_cnt[ch] <= prev && k < 3000) begin
         @(posedge CLK);
         k++;
      end
      check("done_wait", 32'(done_cnt[ch] > prev), 32'd1);
      @(negedge CLK);
   endtask

   initial begin
      #3000000;
      $display("FAIL global_timeout: got running expected finished");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      int prev;
      int k;
      logic sawerr;
      logic [1:0]  rr_sec [6];
      logic [11:0] rr_adr [6];

      vt[0] = '{2'd0, 12'h100, 8'd10, 31, 1,
                '{12'h100, 12'h0, 12'h0, 12'h0}, '{5'd9, 5'd0, 5'd0, 5'd0}};
      vt[1] = '{2'd2, 12'h010, 8'd40, 31, 3,
                '{12'h010, 12'h020, 12'h030, 12'h0}, '{5'd15, 5'd15, 5'd7, 5'd0}};
      vt[2] = '{2'd1, 12'hFF8, 8'd20, 31, 2,
                '{12'hFF8, 12'h008, 12'h0, 12'h0}, '{5'd15, 5'd3, 5'd0, 5'd0}};
      vt[3] = '{2'd3, 12'h000, 8'd16, 31, 1,
                '{12'h000, 12'h0, 12'h0, 12'h0}, '{5'd15, 5'd0, 5'd0, 5'd0}};
      vt[4] = '{2'd0, 12'h7FF, 8'd17, 31, 2,
                '{12'h7FF, 12'h80F, 12'h0, 12'h0}, '{5'd15, 5'd0, 5'd0, 5'd0}};
      vt[5] = '{2'd0, 12'hFFC, 8'd16, 5, 4,
                '{12'hFFC, 12'h001, 12'h006, 12'h00B}, '{5'd15, 5'd10, 5'd5, 5'd0}};

      RST = 1'b0;
      LOAD = 1'b0;
      LOAD_CH = 2'd0;
      LOAD_ADDR = 12'd0;
      LOAD_LEN = 8'd0;
      LSAB_FULL = 4'd0;
      repeat (3) @(negedge CLK);
      check("rst_load_ack", 32'(LOAD_ACK), 0);
      check("rst_busy", 32'(CH_BUSY), 0);
      check("rst_done", 32'(CH_DONE), 0);
      check("rst_err", 32'(CH_ERR), 0);
      check("rst_issue", 32'(MV_ISSUE), 0);
      check("rst_addr", 32'(MV_START_ADDRESS), 0);
      check("rst_cnt", 32'(MV_COUNT_REQ), 0);
      check("rst_sec", 32'(MV_SECTION), 0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      // LOAD edge, grant edge, then MV_ISSUE visible.
      prev = done_cnt[3];
      LOAD = 1'b1;
      LOAD_CH = 2'd3;
      LOAD_ADDR = 12'h0AB;
      LOAD_LEN = 8'd3;
      @(posedge CLK);
      #1 LOAD = 1'b0;
      check("lat_ack", 32'(LOAD_ACK), 1);
      check("lat_issue_early", 32'(MV_ISSUE), 0);
      @(posedge CLK);
      #1;
      check("lat_issue", 32'(MV_ISSUE), 1);
      check("lat_addr", 32'(MV_START_ADDRESS), 32'h0AB);
      check("lat_cnt", 32'(MV_COUNT_REQ), 2);
      check("lat_sec", 32'(MV_SECTION), 3);
      @(posedge CLK);
      #1;
      check("lat_pulse_end", 32'(MV_ISSUE), 0);
      check("lat_addr_hold", 32'(MV_START_ADDRESS), 32'h0AB);
      wait_done(3, prev);
      check("lat_busy_clr", 32'(CH_BUSY[3]), 0);

      for (int v = 0; v < 6; v++) begin
         base = iss_addr.size();
         prev = done_cnt[vt[v].ch];
         sent_cap = vt[v].cap;
         do_load(vt[v].ch, vt[v].addr, vt[v].len, 1'b1);
         wait_done(int'(vt[v].ch), prev);
         check($sformatf("v%0d_nburst", v), 32'(iss_addr.size() - base), 32'(vt[v].nb));
         for (int j = 0; j < vt[v].nb; j++) begin
            if (base + j < iss_addr.size()) begin
               check($sformatf("v%0d_b%0d_addr", v, j), 32'(iss_addr[base + j]), 32'(vt[v].ea[j]));
               check($sformatf("v%0d_b%0d_req", v, j), 32'(iss_req[base + j]), 32'(vt[v].er[j]));
               check($sformatf("v%0d_b%0d_sec", v, j), 32'(iss_sec[base + j]), 32'(vt[v].ch));
            end
         end
         check($sformatf("v%0d_busy", v), 32'(CH_BUSY[vt[v].ch]), 0);
         check($sformatf("v%0d_done_once", v), 32'(done_cnt[vt[v].ch]), 32'(prev + 1));
      end
      sent_cap = 31;

      // Rejections: busy channel and zero length.
      LSAB_FULL = 4'b0010;
      base = iss_addr.size();
      prev = done_cnt[1];
      do_load(2'd1, 12'h200, 8'd8, 1'b1);
      do_load(2'd1, 12'h300, 8'd4, 1'b0);
      do_load(2'd2, 12'h400, 8'd0, 1'b0);
      repeat (3) @(negedge CLK);
      check("rej_busy", 32'(CH_BUSY), 32'b0010);
      check("rej_no_issue", 32'(iss_addr.size() - base), 0);
      LSAB_FULL = 4'b0000;
      wait_done(1, prev);
      check("rej_nburst", 32'(iss_addr.size() - base), 1);
      if (iss_addr.size() > base) begin
         check("rej_addr", 32'(iss_addr[base]), 32'h200);
         check("rej_req", 32'(iss_req[base]), 7);
      end

      // LOAD to a channel in its retiring ACCOUNT cycle.
      base = iss_addr.size();
      do_load(2'd3, 12'h050, 8'd4, 1'b1);
      k = 0;
      while (!MV_WORKING && k < 50) begin
         @(posedge CLK);
         k++;
      end
      while (MV_WORKING && k < 150) begin
         @(posedge CLK);
         k++;
      end
      check("ret_wait", 32'(k < 150), 1);
      @(negedge CLK);
      LOAD = 1'b1;
      LOAD_CH = 2'd3;
      LOAD_ADDR = 12'h555;
      LOAD_LEN = 8'd9;
      @(negedge CLK);
      LOAD = 1'b0;
      check("ret_ack", 32'(LOAD_ACK), 0);
      check("ret_done", 32'(CH_DONE), 32'b1000);
      check("ret_busy", 32'(CH_BUSY), 0);
      repeat (6) @(negedge CLK);
      check("ret_no_reissue", 32'(iss_addr.size() - base), 1);
      check("ret_still_idle", 32'(CH_BUSY), 0);

      // Round-robin with section 1 full.
      LSAB_FULL = 4'b0010;
      base = iss_addr.size();
      rr_sec = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
      rr_adr = '{12'h000, 12'h200, 12'h300, 12'h010, 12'h210, 12'h310};
      begin
         int p0, p1, p2, p3;
         p0 = done_cnt[0];
         p1 = done_cnt[1];
         p2 = done_cnt[2];
         p3 = done_cnt[3];
         do_load(2'd0, 12'h000, 8'd32, 1'b1);
         do_load(2'd1, 12'h100, 8'd32, 1'b1);
         do_load(2'd2, 12'h200, 8'd32, 1'b1);
         do_load(2'd3, 12'h300, 8'd32, 1'b1);
         wait_done(0, p0);
         wait_done(2, p2);
         wait_done(3, p3);
         check("rr_busy", 32'(CH_BUSY), 32'b0010);
         check("rr_nissue", 32'(iss_addr.size() - base), 6);
         for (int j = 0; j < 6; j++) begin
            if (base + j < iss_sec.size()) begin
               check($sformatf("rr_sec%0d", j), 32'(iss_sec[base + j]), 32'(rr_sec[j]));
               check($sformatf("rr_addr%0d", j), 32'(iss_addr[base + j]), 32'(rr_adr[j]));
            end
         end
         LSAB_FULL = 4'b0000;
         wait_done(1, p1);
         if (iss_sec.size() >= base + 8) begin
            check("rr_ch1_sec", 32'(iss_sec[base + 6]), 1);
            check("rr_ch1_addr", 32'(iss_addr[base + 6]), 32'h100);
            check("rr_ch1_addr2", 32'(iss_addr[base + 7]), 32'h110);
         end else begin
            check("rr_ch1_n", 32'(iss_sec.size() - base), 8);
         end
      end

`ifdef FRDRAM_SCHED_TIMEOUT_EN
      LSAB_FULL = 4'b0010;
      stall = 1'b1;
      prev = done_cnt[1];
      k = done_cnt[0];
      do_load(2'd1, 12'h0C0, 8'd4, 1'b1);
      do_load(2'd0, 12'h123, 8'd5, 1'b1);
      begin
         int t = 0;
         while (!MV_ISSUE && t < 20) begin
            @(negedge CLK);
            t++;
         end
      end
      check("wd_issue_sec", 32'(MV_SECTION), 0);
      sawerr = 1'b0;
      repeat (14) begin
         @(negedge CLK);
         if (CH_ERR != 4'd0) sawerr = 1'b1;
      end
      check("wd_no_early_err", 32'(sawerr), 0);
      @(negedge CLK);
      check("wd_err", 32'(CH_ERR), 32'b0001);
      check("wd_busy", 32'(CH_BUSY[0]), 0);
      stall = 1'b0;
      LSAB_FULL = 4'b0000;
      wait_done(1, prev);
      check("wd_next_sec", 32'(iss_sec[iss_sec.size() - 1]), 1);
      check("wd_next_addr", 32'(iss_addr[iss_addr.size() - 1]), 32'h0C0);
      check("wd_no_done0", 32'(done_cnt[0]), 32'(k));
      stall = 1'b1;
      do_load(2'd0, 12'h321, 8'd5, 1'b1);
      repeat (4) @(negedge CLK);
`else
      stall = 1'b1;
      do_load(2'd0, 12'h123, 8'd5, 1'b1);
      repeat (40) @(negedge CLK);
      check("nowd_err", 32'(err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3]), 0);
      check("nowd_busy", 32'(CH_BUSY[0]), 1);
      base = iss_addr.size();
      do_load(2'd1, 12'h0C0, 8'd4, 1'b1);
      repeat (10) @(negedge CLK);
      check("nowd_stuck", 32'(iss_addr.size() - base), 0);
`endif

      // Reset mid-burst drops every descriptor.
      RST = 1'b0;
      #1;
      check("mid_rst_busy", 32'(CH_BUSY), 0);
      check("mid_rst_addr", 32'(MV_START_ADDRESS), 0);
      @(negedge CLK);
      RST = 1'b1;
      stall = 1'b0;
      base = iss_addr.size();
      prev = done_cnt[2];
      do_load(2'd2, 12'h0A0, 8'd3, 1'b1);
      wait_done(2, prev);
      check("post_rst_n", 32'(iss_addr.size() - base), 1);
      if (iss_addr.size() > base) begin
         check("post_rst_addr", 32'(iss_addr[base]), 32'h0A0);
         check("post_rst_req", 32'(iss_req[base]), 2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hyper_frdram_sched.md
# hyper_frdram_sched

Four-channel scheduler sitting in front of the DRAM-to-LSAB block mover (`hyper_mvblck_frdram`). Each channel holds a transfer descriptor (start address, total length) bound to one LSAB section. The scheduler splits each transfer into bursts of at most `MAX_BURST` words, arbitrates round-robin among ready channels, and skips channels whose LSAB section is full. After every burst it advances the channel's address and remaining length by the word count the mover reports.

## Interface
- `MAX_BURST`, default 16: largest burst in words; legal range 2..31.
- `TIMEOUT_CYC`, default 15: watchdog limit in cycles; used only with `FRDRAM_SCHED_TIMEOUT_EN`.

Ports:
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-low.
- `LOAD` in 1: write one descriptor.
- `LOAD_CH` in 2: target channel; channel n uses LSAB section n.
- `LOAD_ADDR` in 12: start DRAM column address.
- `LOAD_LEN` in 8: total words; 0 is illegal and is rejected.
- `LOAD_ACK` out 1: registered; high one cycle after an accepted `LOAD`.
- `LSAB_FULL` in 4: full flag per section.
- `CH_BUSY` out 4: channel holds an unfinished descriptor.
- `CH_DONE` out 4: one-cycle pulse when a channel's remaining length reaches 0.
- `CH_ERR` out 4: one-cycle pulse on a watchdog abort; stays 0 without the macro.
- `MV_START_ADDRESS` out 12: burst start address.
- `MV_COUNT_REQ` out 5: burst length minus 1.
- `MV_SECTION` out 2: burst section.
- `MV_ISSUE` out 1: one-cycle issue pulse.
- `MV_COUNT_SENT` in 5: words the mover wrote in the last burst.
- `MV_WORKING` in 1: mover busy.

## Operation
- Per-channel state: `addr[11:0]`, `rem[7:0]`, `busy`.
- `LOAD` is accepted only if the target channel is not busy and `LOAD_LEN != 0`. Otherwise it is ignored and `LOAD_ACK` stays 0.
- A channel is ready when it is busy and its `LSAB_FULL` bit is 0.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_END, ACCOUNT.
- **IDLE:** if any channel is ready, grant the first ready channel at or after round-robin pointer `rr`, then go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:**
  - `burst = min(rem, MAX_BURST)`.
  - Drive `MV_START_ADDRESS = addr`, `MV_COUNT_REQ = burst-1`, `MV_SECTION = ch`.
  - Pulse `MV_ISSUE` for one cycle, then go to WAIT_START.
- **WAIT_START:** wait for `MV_WORKING = 1`, then go to WAIT_END.
- **WAIT_END:** wait for `MV_WORKING = 0`, then go to ACCOUNT.
- **ACCOUNT:**
  - `n = min(MV_COUNT_SENT, burst)`.
  - `addr += n` (modulo 4096, wraps).
  - `rem -= n`.
  - If `rem` becomes 0: clear `busy` and pulse `CH_DONE[ch]`.
  - Set `rr = ch+1` (mod 4) in every case, so a channel whose burst was cut short by a full LSAB does not starve the others.
  - Go to IDLE.
- A burst stopped early (`n < burst`) leaves the channel busy. It is re-issued later from the updated address. An `n = 0` burst is legal.
- An `LSAB_FULL` change after grant does not cancel the issue; the mover handles an abrupt stop itself.
- If `LOAD` targets the channel being retired in ACCOUNT, `CH_DONE` happens first. The `LOAD` is rejected, because the channel is still busy that cycle.

## Timing
- Reset values: `LOAD_ACK`, `CH_BUSY`, `CH_DONE`, `CH_ERR`, `MV_ISSUE` are 0; `MV_START_ADDRESS`, `MV_COUNT_REQ`, `MV_SECTION` are 0; FSM is IDLE; `rr` is 0; all channel state is cleared.
- An assertion of `RST` mid-burst drops all descriptors. The mover is reset by the same `RST`.
- All outputs are registered.
- Minimum latency from `LOAD` to `MV_ISSUE` is 2 cycles: the `LOAD` edge, then IDLE grant, then the ISSUE pulse.
- `MV_*` address, count and section outputs hold stable from the ISSUE cycle until ACCOUNT.
- `MV_COUNT_SENT` is sampled in the ACCOUNT cycle, which is the first cycle `MV_WORKING` is seen low.
- `CH_DONE` is high in the cycle after ACCOUNT; `CH_BUSY` falls on the same edge.
- Minimum spacing between consecutive `MV_ISSUE` pulses is burst duration + 4 cycles.

## Configuration
- `FRDRAM_SCHED_TIMEOUT_EN`, when defined, adds a watchdog counter in WAIT_START:
  - If `MV_WORKING` is not seen within `TIMEOUT_CYC` cycles after `MV_ISSUE`, clear the channel's `busy`.
  - Pulse `CH_ERR[ch]`; do not pulse `CH_DONE`.
  - Set `rr = ch+1` and return to IDLE.
- When undefined, WAIT_START waits indefinitely and `CH_ERR` is tied to 0.

## Test plan
- **Single channel, short transfer:** load ch0, addr 0x100, len 10, mover echoes `COUNT_SENT` = 10 → one `MV_ISSUE` with addr 0x100, `COUNT_REQ` 9, section 0; `CH_DONE[0]` pulses; `CH_BUSY[0]` falls.
- **Burst splitting:** load ch2, addr 0x010, len 40 → three bursts at 0x010/16, 0x020/16, 0x030/8; `COUNT_REQ` 15, 15, 7; one `CH_DONE[2]`.
- **Round-robin and LSAB full:** load ch0..ch3 with len 32 each and hold `LSAB_FULL[1]` = 1 → issue order 0, 2, 3, 0, 2, 3. Releasing full → ch1 is served next, and ch1's first burst starts at its original address.
- **Early stop:** ch0 addr 0xFFC, len 16, mover reports `COUNT_SENT` 5 → `rem` = 11; next burst addr 0x001 (wrap), `COUNT_REQ` 10; no `CH_DONE` after the first burst.
- **Load rejection:** `LOAD` to busy ch1, `LOAD` with `LOAD_LEN` = 0, and `LOAD` to ch3 in its retiring ACCOUNT cycle → `LOAD_ACK` 0 in all three cases; descriptors unchanged; ch3 `CH_DONE` pulses.
- **Watchdog (macro defined):** `MV_WORKING` held 0 after `MV_ISSUE` → `CH_ERR[ch]` pulses 15 cycles later; channel not busy; scheduler serves the next ready channel. With the macro undefined, the FSM stays in WAIT_START.
